// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CBC/CTR session sequencer in front of an iterative AES-128 core.
// Exactly one block is in flight; chaining and counter state live here, not in the core.
module aes_mode_ctrl #(
    parameter int NBLK_W = 16,
    parameter int CTR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_in,
    input  logic [1:0]        mode_in,
    input  logic [NBLK_W-1:0] nblocks_in,
    input  logic [127:0]      key_in,
    input  logic [127:0]      iv_in,
    input  logic              blk_valid_in,
    input  logic [127:0]      blk_data_in,
    output logic              blk_ready_out,
    output logic              out_valid_out,
    output logic [127:0]      out_data_out,
    input  logic              out_ready_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              core_start_out,
    output logic [127:0]      core_data_out,
    output logic [127:0]      core_key_out,
    input  logic [127:0]      core_data_in,
    input  logic              core_valid_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_RUN,
        S_OUT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_ECB,
        M_CBC,
        M_CTR
    } mode_t;

    state_t            state;
    state_t            state_n;
    mode_t             mode_r;
    mode_t             mode_dec;
    logic [NBLK_W-1:0] rem_r;
    logic [127:0]      key_r;
    logic [127:0]      chain_r;
    logic [127:0]      pt_r;
    logic [127:0]      cdata_r;
    logic [127:0]      out_r;

    logic              start_acc;
    logic              blk_acc;
    logic              core_done;
    logic [127:0]      cin;
    logic [127:0]      res;
    logic [127:0]      chain_nx;
    logic [127:0]      ctr_inc;

    assign start_acc = (state == S_IDLE) && start_in;
    assign blk_acc   = (state == S_LOAD) && blk_valid_in;
    assign core_done = (state == S_RUN) && core_valid_in;

    always_comb begin
        mode_dec = M_ECB;
        unique case (1'b1)
            mode_in == 2'b01: mode_dec = M_CBC;
            mode_in == 2'b10: mode_dec = M_CTR;
            default:          mode_dec = M_ECB;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start_in) begin
                    state_n = (nblocks_in == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (blk_valid_in) begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_RUN;
            S_RUN: begin
                if (core_valid_in) begin
                    state_n = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_in) begin
                    state_n = (rem_r == '0) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Only the low CTR_W bits count; the carry out of that field is dropped.
    always_comb begin
        ctr_inc = chain_r;
        ctr_inc[CTR_W-1:0] = chain_r[CTR_W-1:0] + CTR_W'(1);
    end

    always_comb begin
        cin = blk_data_in;
        unique case (1'b1)
            mode_r == M_CBC: cin = blk_data_in ^ chain_r;
            mode_r == M_CTR: cin = chain_r;
            default:         cin = blk_data_in;
        endcase
    end

    always_comb begin
        res      = core_data_in;
        chain_nx = chain_r;
        unique case (1'b1)
            mode_r == M_CBC: chain_nx = core_data_in;
            mode_r == M_CTR: begin
                res      = pt_r ^ core_data_in;
                chain_nx = ctr_inc;
            end
            default: res = core_data_in;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_r  <= M_ECB;
            rem_r   <= '0;
            key_r   <= '0;
            chain_r <= '0;
            pt_r    <= '0;
            cdata_r <= '0;
            out_r   <= '0;
        end else begin
            if (start_acc) begin
                mode_r  <= mode_dec;
                rem_r   <= nblocks_in;
                key_r   <= key_in;
                chain_r <= iv_in;
            end
            if (blk_acc) begin
                pt_r    <= blk_data_in;
                cdata_r <= cin;
            end
            if (core_done) begin
                out_r   <= res;
                chain_r <= chain_nx;
                rem_r   <= rem_r - NBLK_W'(1);
            end
        end
    end

    assign blk_ready_out  = (state == S_LOAD);
    assign core_start_out = (state == S_ISSUE);
    assign out_valid_out  = (state == S_OUT);
    assign done_out       = (state == S_DONE);
    assign busy_out       = (state != S_IDLE);
    assign out_data_out   = out_r;
    assign core_data_out  = cdata_r;
    assign core_key_out   = key_r;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: scoreboard bench with a behavioural core of variable latency.
// Expected core inputs and outputs are queued per session and popped as the DUT emits them.
module tb_aes_mode_ctrl;

    localparam int NBLK_W = 16;
    localparam int CTR_W  = 32;
    localparam int LIM    = 300;

    localparam logic [127:0] K1 = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] P1 = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] C1 = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] P2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] P3 = 128'hdeadbeef00112233cafef00d44556677;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV_CTR = 128'h00112233445566778899aabbffffffff;
    localparam logic [127:0] IV_CBC = 128'h0badc0de0badc0de0badc0de0badc0de;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start_in = 1'b0;
    logic [1:0]        mode_in = '0;
    logic [NBLK_W-1:0] nblocks_in = '0;
    logic [127:0]      key_in = '0;
    logic [127:0]      iv_in = '0;
    logic              blk_valid_in = 1'b0;
    logic [127:0]      blk_data_in = '0;
    logic              blk_ready_out;
    logic              out_valid_out;
    logic [127:0]      out_data_out;
    logic              out_ready_in = 1'b1;
    logic              busy_out;
    logic              done_out;
    logic              core_start_out;
    logic [127:0]      core_data_out;
    logic [127:0]      core_key_out;
    logic [127:0]      core_data_in = '0;
    logic              core_valid_in = 1'b0;

    aes_mode_ctrl #(.NBLK_W(NBLK_W), .CTR_W(CTR_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start_in       (start_in),
        .mode_in        (mode_in),
        .nblocks_in     (nblocks_in),
        .key_in         (key_in),
        .iv_in          (iv_in),
        .blk_valid_in   (blk_valid_in),
        .blk_data_in    (blk_data_in),
        .blk_ready_out  (blk_ready_out),
        .out_valid_out  (out_valid_out),
        .out_data_out   (out_data_out),
        .out_ready_in   (out_ready_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .core_start_out (core_start_out),
        .core_data_out  (core_data_out),
        .core_key_out   (core_key_out),
        .core_data_in   (core_data_in),
        .core_valid_in  (core_valid_in)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stand-in cipher: the known AES-128 vector, otherwise a cheap keyed mix.
    function automatic logic [127:0] fcipher(input logic [127:0] d, input logic [127:0] k);
        if (d == P1 && k == K1) return C1;
        return {d[118:0], d[127:119]} ^ k ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    logic [127:0] q_cin[$];
    logic [127:0] q_out[$];
    logic [127:0] blocks[$];
    logic [127:0] cur_key = '0;
    logic [127:0] lat_d = '0;
    logic [127:0] lat_k = '0;

    int lat = 1, hold = 1, pending = 0, hold_left = 0;
    int stall = 0, stall_left = 0;
    int starts = 0, n_out = 0, cyc = 0, last_acc = 0;
    bit rnd_ready = 0, cv_fresh = 0, cv_stale = 0, abort_flag = 0;
    bit done_prev = 0, acc_valid = 0;

    always @(negedge CLK) begin
        cyc++;
        if (done_prev) begin
            check("done_pulse", done_out, 0);
            check("busy_drop", busy_out, 0);
        end
        if (done_out && acc_valid) begin
            check("done_lat", cyc, last_acc + 1);
            acc_valid = 0;
        end
        done_prev = done_out;

        if (cv_fresh) begin
            if (cv_stale) check("ov_after_rst", out_valid_out, 0);
            else check("ov_lat", out_valid_out, 1);
            cv_fresh = 0;
        end
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) core_valid_in = 1'b0;
        end
        if (pending > 0) begin
            pending--;
            if (pending == 0) begin
                core_valid_in = 1'b1;
                core_data_in  = fcipher(lat_d, lat_k);
                hold_left     = hold;
                cv_fresh      = 1;
                cv_stale      = abort_flag;
                abort_flag    = 0;
            end
        end
        if (core_start_out) begin
            starts++;
            lat_d   = core_data_out;
            lat_k   = core_key_out;
            pending = lat;
            check("core_key", core_key_out, cur_key);
            if (q_cin.size() == 0) check("core_start_extra", core_start_out, 0);
            else check("core_in", core_data_out, q_cin.pop_front());
        end

        if (out_valid_out && stall_left > 0) begin
            out_ready_in = 1'b0;
            stall_left--;
        end else if (rnd_ready) begin
            out_ready_in = ($urandom_range(0, 2) != 0);
        end else begin
            out_ready_in = 1'b1;
        end
        if (out_valid_out) begin
            if (q_out.size() == 0) begin
                check("out_extra", out_valid_out, 0);
            end else if (out_ready_in) begin
                check("out_data", out_data_out, q_out.pop_front());
                n_out++;
                last_acc   = cyc;
                acc_valid  = 1;
                stall_left = stall;
            end else begin
                check("stall_data", out_data_out, q_out[0]);
                check("stall_rdy", blk_ready_out, 0);
                check("stall_cs", core_start_out, 0);
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_flags"},
              {blk_ready_out, out_valid_out, busy_out, done_out, core_start_out}, 0);
        check({tag, "_odata"}, out_data_out, 0);
        check({tag, "_cdata"}, core_data_out, 0);
        check({tag, "_ckey"}, core_key_out, 0);
    endtask

    task automatic session(input logic [1:0] md, input int n, input logic [127:0] k,
                           input logic [127:0] iv, input int stall_in, input bit rnd,
                           input bit poke);
        logic [127:0] ch, cin, e, p;
        int t;
        ch = iv;
        for (int i = 0; i < n; i++) begin
            p = blocks[i];
            case (md)
                2'b01:   cin = p ^ ch;
                2'b10:   cin = ch;
                default: cin = p;
            endcase
            e = fcipher(cin, k);
            q_cin.push_back(cin);
            case (md)
                2'b01: begin
                    q_out.push_back(e);
                    ch = e;
                end
                2'b10: begin
                    q_out.push_back(p ^ e);
                    ch[31:0] = ch[31:0] + 32'd1;
                end
                default: q_out.push_back(e);
            endcase
        end
        starts = 0;
        n_out = 0;
        cur_key = k;
        stall = stall_in;
        stall_left = stall_in;
        rnd_ready = rnd;

        @(negedge CLK);
        start_in = 1'b1;
        mode_in = md;
        nblocks_in = NBLK_W'(n);
        key_in = k;
        iv_in = iv;
        @(negedge CLK);
        start_in = 1'b0;
        mode_in = '0;
        nblocks_in = '0;
        key_in = '0;
        iv_in = '0;
        check("busy_start", busy_out, 1);
        if (n == 0) begin
            check("done_n0", done_out, 1);
            @(negedge CLK);
            check("busy_n0", busy_out, 0);
            check("starts_n0", starts, 0);
            return;
        end
        check("ready_t1", blk_ready_out, 1);

        for (int i = 0; i < n; i++) begin
            blk_valid_in = 1'b1;
            blk_data_in = blocks[i];
            t = 0;
            while (!blk_ready_out && t < LIM) begin
                @(negedge CLK);
                t++;
                start_in = poke && (i == 1) && (t == 1);
                nblocks_in = start_in ? NBLK_W'(7) : '0;
            end
            start_in = 1'b0;
            nblocks_in = '0;
            check("blk_wait", blk_ready_out, 1);
            @(negedge CLK);
            check("cs_a1", core_start_out, 1);
            check("ready_a1", blk_ready_out, 0);
        end
        blk_valid_in = 1'b0;

        t = 0;
        while (!done_out && t < LIM) begin
            @(negedge CLK);
            t++;
        end
        check("done_seen", done_out, 1);
        @(negedge CLK);
        check("starts", starts, n);
        check("n_out", n_out, n);
        check("q_out_empty", q_out.size(), 0);
        rnd_ready = 0;
        stall = 0;
        stall_left = 0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check_idle("reset");
        RST = 1'b0;
        @(negedge CLK);
        check_idle("post_reset");

        blocks = '{P1};
        session(2'b00, 1, K1, '0, 0, 0, 0);

        blocks = '{P1, P2};
        session(2'b01, 2, K1, '0, 0, 0, 0);

        lat = 2;
        session(2'b10, 2, K2, IV_CTR, 0, 0, 1);

        lat = 3;
        hold = 2;
        session(2'b00, 2, K2, '0, 5, 0, 0);

        hold = 1;
        blocks = '{P1, P2, P3};
        session(2'b11, 3, K1, '0, 0, 1, 0);

        session(2'b01, 0, K2, IV_CBC, 0, 0, 0);

        lat = 6;
        cur_key = K2;
        q_cin.delete();
        q_out.delete();
        q_cin.push_back(IV_CTR);
        @(negedge CLK);
        start_in = 1'b1;
        mode_in = 2'b10;
        nblocks_in = NBLK_W'(2);
        key_in = K2;
        iv_in = IV_CTR;
        @(negedge CLK);
        start_in = 1'b0;
        blk_valid_in = 1'b1;
        blk_data_in = P3;
        @(negedge CLK);
        blk_valid_in = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_pre_busy", busy_out, 1);
        #2;
        RST = 1'b1;
        abort_flag = 1;
        #1;
        check_idle("rst_mid");
        @(negedge CLK);
        #2;
        RST = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            check("rst_no_ov", out_valid_out, 0);
            check("rst_no_done", done_out, 0);
        end
        check("rst_cv_seen", abort_flag, 0);

        lat = 2;
        session(2'b01, 3, K2, IV_CBC, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
# aes_mode_ctrl

Block-cipher mode controller that sits between the system data stream and the iterative AES-128 core (AES_TOP). It runs a session of N 128-bit blocks in ECB, CBC or CTR mode, with valid/ready handshakes on both data ports. It owns chaining and counter state and sequences the core one block at a time; the core itself is instantiated beside it and wired through the core_* ports.

## Interface
Parameters:
- NBLK_W, default 16: width of the session block count; maximum session length is 2^NBLK_W−1 blocks.
- CTR_W, default 32: number of low-order counter-block bits incremented in CTR mode (1..128).

Ports (128-bit buses: bits [127:96] = word0 … [31:0] = word3, matching core word order):
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start_in  in  1  one-cycle session start; sampled only in IDLE
- mode_in  in  2  00 ECB, 01 CBC, 10 CTR, 11 treated as ECB; latched at start
- nblocks_in  in  NBLK_W  blocks in session; latched at start
- key_in  in  128  cipher key; latched at start
- iv_in  in  128  CBC IV / CTR initial counter block; latched at start
- blk_valid_in  in  1  input block valid
- blk_data_in  in  128  input block (plaintext)
- blk_ready_out  out  1  input block accepted when valid&ready
- out_valid_out  out  1  output block valid
- out_data_out  out  128  output block (ciphertext)
- out_ready_in  in  1  downstream accepts output
- busy_out  out  1  session in progress (not IDLE)
- done_out  out  1  one-cycle pulse, session complete
- core_start_out  out  1  one-cycle start pulse to core
- core_data_out  out  128  core plaintext input, held stable while core runs
- core_key_out  out  128  core key, equals latched key for the whole session
- core_data_in  in  128  core ciphertext
- core_valid_in  in  1  core result valid (pulse or level; first cycle counts)

## Operation
- FSM states: IDLE → (start) LOAD → ISSUE → RUN → OUT → LOAD … → DONE → IDLE.
- IDLE: start_in=1 latches mode, count, key, iv. chain_r = iv. If nblocks_in=0, go to DONE with no core activity. Otherwise go to LOAD.
- LOAD: blk_ready_out=1. On blk_valid_in, capture P into pt_r and form the core input:
  - ECB: P.
  - CBC: P ^ chain_r.
  - CTR: chain_r (the counter block).
- ISSUE: core_start_out=1 for exactly one cycle, then go to RUN.
- RUN: wait for core_valid_in, then capture E into the output register:
  - ECB: E.
  - CBC: E; also chain_r ← E.
  - CTR: pt_r ^ E; also chain_r[CTR_W−1:0] += 1, mod 2^CTR_W. Bits above CTR_W never change; wrap from all-ones to zero carries nowhere.
  - Decrement the remaining count, then go to OUT.
- OUT: out_valid_out=1 and out_data_out stable until out_ready_in. On accept: remaining=0 → DONE, else → LOAD.
- DONE: done_out=1 for one cycle, then go to IDLE.
- Handshake and event rules:
  - start_in outside IDLE is ignored.
  - core_valid_in outside RUN is ignored.
  - blk_valid_in outside LOAD is not accepted; blk_ready_out=0.
- Only one block is in flight; no overlap of input, core and output phases.

## Timing
- Reset (async, RST=1): state IDLE; all outputs 0, including core_data_out and core_key_out; chain_r, pt_r and counters cleared. Deassertion takes effect on the next rising edge.
- Reset mid-session aborts immediately with no done_out. A core result arriving after reset is ignored.
- start accepted at edge T: blk_ready_out=1 from T+1.
- Block accepted at edge A: core_start_out high in cycle A+1; core_data_out valid from A+1 and held until the next LOAD acceptance.
- core_valid_in sampled at edge V: out_valid_out high from V+1.
- Last output accepted at edge X: done_out high in cycle X+1; busy_out=0 from X+2.
- nblocks_in=0: done_out high in the cycle after start; no core_start_out.
- Per-block throughput = core latency + 3 cycles, plus any handshake stalls.

## Test plan
- ECB, key 5468617473206d79204b756e67204675, P 54776f204f6e65204e696e652054776f, nblocks=1 → out 29c3505f571420f6402299b31a02d73a, one core_start_out, done_out one cycle after output accept.
- CBC, IV=0, same two blocks as ECB → first outputs equal; second block's core_data_out = P2 ^ C1.
- CTR, iv low word ffffffff, CTR_W=32, 2 blocks → second core_data_out low word 00000000 with upper 96 bits unchanged; out = P ^ core_data_in.
- Backpressure: hold out_ready_in=0 for 5 cycles → out_valid_out and out_data_out stable; blk_ready_out=0; no extra core_start_out.
- nblocks=0 → done_out next cycle, busy_out drops, no core activity. start_in pulsed while busy → ignored; session count unchanged.
- RST pulse while in RUN → all outputs 0 immediately. A core_valid_in arriving afterwards produces no out_valid_out.
